manchester_chip_rx: RTL

Front-end chip receiver for the optical RX path, sitting directly upstream of the combinational Manchester decoder. It samples the raw receiver comparator line at `OVERSAMPLE` clocks per chip and recovers chip phase from line transitions. It then hunts for the sync word and delivers word-aligned 16-chip groups, with a valid strobe, for the decoder to turn into bytes. It also flags Manchester code violations and aborts a frame on line loss.

---
 rtl/apollo_rx_pkg.sv | 23 ++
 rtl/rx_edge_sync.sv | 31 +++
 rtl/manchester_chip_rx.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/apollo_rx_pkg.sv
// Shared types and constants for the optical RX chip front end.
package apollo_rx_pkg;

  localparam int unsigned CHIP_W = 16;
  localparam logic [CHIP_W-1:0] SYNC_WORD_DEFAULT = 16'hE1D2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HUNT = 2'd1,
    RECV = 2'd2
  } rx_state_e;

  // A Manchester pair is legal only when its two chips differ.
  function automatic logic has_code_err(input logic [CHIP_W-1:0] word);
    logic err;
    err = 1'b0;
    for (int i = 0; i < CHIP_W / 2; i++) begin
      err = err | ~(word[2*i+1] ^ word[2*i]);
    end
    return err;
  endfunction

endpackage

// File: rtl/rx_edge_sync.sv
// Two-flop synchronizer for the raw comparator line plus a one-flop edge detector.
module rx_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_i,
  output logic rx_s_o,
  output logic edge_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rx_s_o = sync2_q;
  assign edge_o = sync2_q ^ prev_q;

endmodule

// File: rtl/manchester_chip_rx.sv
// Chip-phase recovery, sync hunt and word-aligned 16-chip delivery for the Manchester decoder.
module manchester_chip_rx
  import apollo_rx_pkg::*;
#(
  parameter int unsigned       OVERSAMPLE  = 8,
  parameter logic [CHIP_W-1:0] SYNC_WORD   = SYNC_WORD_DEFAULT,
  parameter int unsigned       FRAME_WORDS = 16,
  parameter int unsigned       LOSS_CHIPS  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              rx_in,
  output logic [CHIP_W-1:0] chip_word,
  output logic              word_valid,
  output logic              code_err,
  output logic              frame_start,
  output logic              frame_end,
  output logic              frame_abort,
  output logic              busy
);

  localparam int unsigned PH_W       = $clog2(OVERSAMPLE);
  localparam int unsigned CC_W       = $clog2(CHIP_W);
  localparam int unsigned WC_W       = $clog2(FRAME_WORDS + 1);
  localparam int unsigned LOSS_LIMIT = LOSS_CHIPS * OVERSAMPLE;
  localparam int unsigned LOSS_W     = $clog2(LOSS_LIMIT + 1);

  logic rx_s;
  logic rx_edge;

  rx_edge_sync u_edge_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx_i   (rx_in),
    .rx_s_o (rx_s),
    .edge_o (rx_edge)
  );

  rx_state_e         state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [CHIP_W-1:0] sr_q, sr_d, sr_next;
  logic [CC_W-1:0]   chip_cnt_q, chip_cnt_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic [LOSS_W-1:0] loss_q, loss_d;
  logic [CHIP_W-1:0] chip_word_q, chip_word_d;
  logic              word_valid_q, word_valid_d;
  logic              code_err_q, code_err_d;
  logic              frame_start_q, frame_start_d;
  logic              frame_end_q, frame_end_d;
  logic              frame_abort_q, frame_abort_d;
  logic              sample;

  // NOTE: every variable driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    sr_d          = sr_q;
    chip_cnt_d    = chip_cnt_q;
    word_cnt_d    = word_cnt_q;
    loss_d        = '0;
    chip_word_d   = chip_word_q;
    word_valid_d  = 1'b0;
    code_err_d    = 1'b0;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    frame_abort_d = 1'b0;
    sample        = 1'b0;
    sr_next       = {sr_q[CHIP_W-2:0], rx_s};

    if (!enable) begin
      state_d       = IDLE;
      phase_d       = '0;
      sr_d          = '0;
      chip_cnt_d    = '0;
      word_cnt_d    = '0;
      frame_abort_d = (state_q == RECV);
    end else begin
      // An edge re-centres the phase and suppresses a coincident sample.
      if (rx_edge) begin
        phase_d = '0;
      end else begin
        phase_d = (phase_q == PH_W'(OVERSAMPLE - 1)) ? '0 : phase_q + 1'b1;
        sample  = (phase_q == PH_W'(OVERSAMPLE / 2));
      end
      if (sample) sr_d = sr_next;

      unique case (state_q)
        IDLE: state_d = HUNT;
        HUNT: begin
          if (sample && sr_next == SYNC_WORD) begin
            frame_start_d = 1'b1;
            chip_cnt_d    = '0;
            word_cnt_d    = '0;
            state_d       = RECV;
          end
        end
        RECV: begin
          if (!rx_edge) loss_d = loss_q + 1'b1;
          if (sample) begin
            if (chip_cnt_q == CC_W'(CHIP_W - 1)) begin
              chip_cnt_d   = '0;
              chip_word_d  = sr_next;
              word_valid_d = 1'b1;
              code_err_d   = has_code_err(sr_next);
              word_cnt_d   = word_cnt_q + 1'b1;
              if (word_cnt_q == WC_W'(FRAME_WORDS - 1)) begin
                frame_end_d = 1'b1;
                state_d     = HUNT;
              end
            end else begin
              chip_cnt_d = chip_cnt_q + 1'b1;
            end
          end
          // Loss wins the state but a word completing this cycle still goes out.
          if (!rx_edge && loss_q == LOSS_W'(LOSS_LIMIT - 1)) begin
            frame_abort_d = 1'b1;
            loss_d        = '0;
            state_d       = HUNT;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      phase_q       <= '0;
      sr_q          <= '0;
      chip_cnt_q    <= '0;
      word_cnt_q    <= '0;
      loss_q        <= '0;
      chip_word_q   <= '0;
      word_valid_q  <= 1'b0;
      code_err_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      sr_q          <= sr_d;
      chip_cnt_q    <= chip_cnt_d;
      word_cnt_q    <= word_cnt_d;
      loss_q        <= loss_d;
      chip_word_q   <= chip_word_d;
      word_valid_q  <= word_valid_d;
      code_err_q    <= code_err_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  assign chip_word   = chip_word_q;
  assign word_valid  = word_valid_q;
  assign code_err    = code_err_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign frame_abort = frame_abort_q;
  assign busy        = (state_q == RECV);

endmodule
